// File: rtl/lcd_init_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the HD44780 4-bit initialisation sequencer and the
// nibble-mode LCD writer it drives: FSM state encoding, writer mode codes,
// the power-on initialisation table and default 50 MHz timing constants.
// ----------------------------------------------------------------------------
package lcd_pkg;

    typedef enum logic [3:0] {
        S_POWERUP,
        S_ISSUE,
        S_WAIT_DONE,
        S_DELAY,
        S_READY,
        S_CMD_ISSUE,
        S_CMD_WAIT_DONE,
        S_CMD_DELAY,
        S_ERROR
    } state_e;

    // Writer mode codes, shared with the nibble-mode writer.
    localparam logic [1:0] MODE_NIBBLE = 2'd0;
    localparam logic [1:0] MODE_BYTE   = 2'd1;

    // Which post-write wait an init step needs.
    typedef enum logic [1:0] {
        DLY_4100US,
        DLY_100US,
        DLY_40US,
        DLY_CLEAR
    } dly_sel_e;

    typedef struct packed {
        logic [1:0] mode;
        logic [7:0] data;   // nibble steps use data[3:0]
        dly_sel_e   dly;
    } init_step_t;

    localparam int unsigned INIT_STEPS = 8;

    // 4-bit wake-up (3,3,3,2), then function set, entry mode, display on,
    // clear. All init writes are commands (RS = 0).
    localparam init_step_t INIT_TABLE [INIT_STEPS] = '{
        '{MODE_NIBBLE, 8'h03, DLY_4100US},
        '{MODE_NIBBLE, 8'h03, DLY_100US},
        '{MODE_NIBBLE, 8'h03, DLY_40US},
        '{MODE_NIBBLE, 8'h02, DLY_40US},
        '{MODE_BYTE,   8'h28, DLY_40US},
        '{MODE_BYTE,   8'h06, DLY_40US},
        '{MODE_BYTE,   8'h0C, DLY_40US},
        '{MODE_BYTE,   8'h01, DLY_CLEAR}
    };

    // Default timings in 50 MHz clock cycles.
    localparam int unsigned DEF_T_POWERUP      = 750000;  // 15 ms
    localparam int unsigned DEF_T_4100US       = 205000;  // 4.1 ms
    localparam int unsigned DEF_T_100US        = 5000;    // 100 us
    localparam int unsigned DEF_T_40US         = 2000;    // 40 us
    localparam int unsigned DEF_T_CLEAR        = 82000;   // 1.64 ms
    localparam int unsigned DEF_T_DONE_TIMEOUT = 10000;

    // Clear display (0x01) and return home (0x02/0x03) need the long wait.
    function automatic logic is_clear_home(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'd0);
    endfunction

endpackage

// File: rtl/lcd_init_sequencer_if.sv
// ----------------------------------------------------------------------------
// lcd_init_sequencer_if
// Sequencer-to-writer bus.
//   oWrite_Start  one-cycle start pulse to the writer
//   oWrite_Mode   MODE_NIBBLE or MODE_BYTE
//   oData_Nibble  nibble for nibble mode
//   oData_Byte    byte for byte mode (sent high nibble first)
//   oRS           LCD register select (0 = command, 1 = data)
//   iWrite_Done   one-cycle pulse from the writer when the write completes
// master = sequencer, slave = writer.
// ----------------------------------------------------------------------------
interface lcd_init_sequencer_if;
    logic       oWrite_Start;
    logic [1:0] oWrite_Mode;
    logic [3:0] oData_Nibble;
    logic [7:0] oData_Byte;
    logic       oRS;
    logic       iWrite_Done;

    modport master (
        output oWrite_Start, oWrite_Mode, oData_Nibble, oData_Byte, oRS,
        input  iWrite_Done
    );

    modport slave (
        input  oWrite_Start, oWrite_Mode, oData_Nibble, oData_Byte, oRS,
        output iWrite_Done
    );
endinterface

// File: rtl/lcd_delay_counter.sv
// ----------------------------------------------------------------------------
// lcd_delay_counter
// 32-bit cycle counter shared by every wait and by the writer timeout.
//   Clock      system clock
//   Reset      synchronous active-high reset
//   clear_i    zero the count (asserted on each state change)
//   enable_i   count this cycle
//   target_i   wait length N in cycles
//   expired_o  high in the N-th enabled cycle (count == N-1)
// ----------------------------------------------------------------------------
module lcd_delay_counter (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        clear_i,
    input  logic        enable_i,
    input  logic [31:0] target_i,
    output logic        expired_o
);

    logic [31:0] count_q;

    // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset || clear_i) begin
            count_q <= '0;
        end else if (enable_i) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign expired_o = enable_i && (count_q == target_i - 32'd1);

endmodule

// File: rtl/lcd_init_sequencer.sv
// ----------------------------------------------------------------------------
// lcd_init_sequencer
// Runs the HD44780 4-bit power-on initialisation through the nibble-mode
// writer, then forwards user command/data bytes with the proper post-write wait.
//   Clock, Reset  50 MHz clock, synchronous active-high reset
//   wr            writer bus (master side)
//   iCmd_Valid    user request valid (held until accepted)
//   iCmd_Data     user byte
//   iCmd_RS       user register select
//   oCmd_Ready    high only in S_READY
//   oInit_Done    sticky, set when the init table completes
//   oError        sticky, set on a writer timeout; only Reset clears it
// ----------------------------------------------------------------------------
module lcd_init_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned T_POWERUP      = DEF_T_POWERUP,
    parameter int unsigned T_4100US       = DEF_T_4100US,
    parameter int unsigned T_100US        = DEF_T_100US,
    parameter int unsigned T_40US         = DEF_T_40US,
    parameter int unsigned T_CLEAR        = DEF_T_CLEAR,
    parameter int unsigned T_DONE_TIMEOUT = DEF_T_DONE_TIMEOUT
) (
    input  logic                 Clock,
    input  logic                 Reset,
    lcd_init_sequencer_if.master wr,
    input  logic                 iCmd_Valid,
    input  logic [7:0]           iCmd_Data,
    input  logic                 iCmd_RS,
    output logic                 oCmd_Ready,
    output logic                 oInit_Done,
    output logic                 oError
);

    localparam logic [2:0] LAST_STEP = 3'(INIT_STEPS - 1);

    state_e      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [7:0]  cmd_data_q, cmd_data_d;
    logic        cmd_rs_q, cmd_rs_d;

    logic        start_q;
    logic [1:0]  mode_q;
    logic [3:0]  nibble_q;
    logic [7:0]  byte_q;
    logic        rs_q;
    logic        ready_q, init_done_q, error_q;

    logic        cnt_en, cnt_expired;
    logic [31:0] cnt_target;
    init_step_t  cur_step;

    function automatic logic [31:0] dly_cycles(input dly_sel_e sel);
        logic [31:0] cycles;
        cycles = T_40US;
        case (sel)
            DLY_4100US: cycles = T_4100US;
            DLY_100US:  cycles = T_100US;
            DLY_40US:   cycles = T_40US;
            DLY_CLEAR:  cycles = T_CLEAR;
            default:    cycles = T_40US;
        endcase
        return cycles;
    endfunction

    // Counter restarts from zero on every state change.
    lcd_delay_counter u_delay (
        .Clock     (Clock),
        .Reset     (Reset),
        .clear_i   (state_d != state_q),
        .enable_i  (cnt_en),
        .target_i  (cnt_target),
        .expired_o (cnt_expired)
    );

    assign cur_step = INIT_TABLE[step_q];

    // NOTE: every variable gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        cmd_data_d = cmd_data_q;
        cmd_rs_d   = cmd_rs_q;
        cnt_en     = 1'b0;
        cnt_target = T_POWERUP;

        unique case (state_q)
            S_POWERUP: begin
                cnt_en     = 1'b1;
                cnt_target = T_POWERUP;
                if (cnt_expired) state_d = S_ISSUE;
            end
            S_ISSUE:     state_d = S_WAIT_DONE;
            S_CMD_ISSUE: state_d = S_CMD_WAIT_DONE;
            S_WAIT_DONE, S_CMD_WAIT_DONE: begin
                cnt_en     = 1'b1;
                cnt_target = T_DONE_TIMEOUT;
                // Done is checked first so it wins over a same-cycle timeout.
                if (wr.iWrite_Done) begin
                    state_d = (state_q == S_WAIT_DONE) ? S_DELAY : S_CMD_DELAY;
                end else if (cnt_expired) begin
                    state_d = S_ERROR;
                end
            end
            S_DELAY: begin
                cnt_en     = 1'b1;
                cnt_target = dly_cycles(cur_step.dly);
                if (cnt_expired) begin
                    if (step_q == LAST_STEP) begin
                        state_d = S_READY;
                    end else begin
                        step_d  = step_q + 3'd1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_READY: begin
                if (iCmd_Valid && ready_q) begin
                    cmd_data_d = iCmd_Data;
                    cmd_rs_d   = iCmd_RS;
                    state_d    = S_CMD_ISSUE;
                end
            end
            S_CMD_DELAY: begin
                cnt_en     = 1'b1;
                cnt_target = is_clear_home(cmd_rs_q, cmd_data_q) ? T_CLEAR : T_40US;
                if (cnt_expired) state_d = S_READY;
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= S_POWERUP;
            step_q      <= '0;
            cmd_data_q  <= '0;
            cmd_rs_q    <= 1'b0;
            start_q     <= 1'b0;
            mode_q      <= MODE_NIBBLE;
            nibble_q    <= '0;
            byte_q      <= '0;
            rs_q        <= 1'b0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            cmd_data_q <= cmd_data_d;
            cmd_rs_q   <= cmd_rs_d;

            // Writer bus lags the issue state by one cycle and then holds
            // until the next issue, keeping it stable while waiting for done.
            start_q <= (state_q == S_ISSUE) || (state_q == S_CMD_ISSUE);
            if (state_q == S_ISSUE) begin
                mode_q   <= cur_step.mode;
                nibble_q <= cur_step.data[3:0];
                byte_q   <= cur_step.data;
                rs_q     <= 1'b0;
            end else if (state_q == S_CMD_ISSUE) begin
                mode_q <= MODE_BYTE;
                byte_q <= cmd_data_q;
                rs_q   <= cmd_rs_q;
            end

            // Ready follows the next state so it drops right after a handshake.
            ready_q     <= (state_d == S_READY);
            init_done_q <= init_done_q ||
                           (state_q == S_DELAY && state_d == S_READY);
            error_q     <= error_q || (state_d == S_ERROR);
        end
    end

    assign wr.oWrite_Start = start_q;
    assign wr.oWrite_Mode  = mode_q;
    assign wr.oData_Nibble = nibble_q;
    assign wr.oData_Byte   = byte_q;
    assign wr.oRS          = rs_q;
    assign oCmd_Ready      = ready_q;
    assign oInit_Done      = init_done_q;
    assign oError          = error_q;

endmodule
